// File: rtl/mix_columns_iter.sv
// Folded AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns of the held state per cycle, with a
// valid/ready handshake on both sides and the mode latched per block.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_inverse,
    output logic         busy
);

    localparam int N = 4 / COLS_PER_CYCLE;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic         inv_q;
    logic         accept;
    logic         last_grp;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One output byte: b0 is the row's own byte, b1..b3 follow cyclically.
    function automatic logic [7:0] mix_row(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic inv);
        logic [7:0] x1_0, x2_0, x3_0;
        logic [7:0] x1_1, x2_1, x3_1;
        logic [7:0] x1_2, x2_2, x3_2;
        logic [7:0] x1_3, x2_3, x3_3;
        x1_0 = xtime(b0); x2_0 = xtime(x1_0); x3_0 = xtime(x2_0);
        x1_1 = xtime(b1); x2_1 = xtime(x1_1); x3_1 = xtime(x2_1);
        x1_2 = xtime(b2); x2_2 = xtime(x1_2); x3_2 = xtime(x2_2);
        x1_3 = xtime(b3); x2_3 = xtime(x1_3); x3_3 = xtime(x2_3);
        if (inv)
            // 14*b0 ^ 11*b1 ^ 13*b2 ^ 9*b3
            return (x3_0 ^ x2_0 ^ x1_0) ^ (x3_1 ^ x1_1 ^ b1)
                 ^ (x3_2 ^ x2_2 ^ b2) ^ (x3_3 ^ b3);
        else
            // 2*b0 ^ 3*b1 ^ b2 ^ b3
            return x1_0 ^ (x1_1 ^ b1) ^ b2 ^ b3;
    endfunction

    // Whole column; row 0 sits in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mix_row(a0, a1, a2, a3, inv), mix_row(a1, a2, a3, a0, inv),
                mix_row(a2, a3, a0, a1, inv), mix_row(a3, a0, a1, a2, inv)};
    endfunction

    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == BUSY);
    assign out_data    = work_q;
    assign out_inverse = inv_q;

    // Next-state, handshake and group counter control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
        last_grp = (cnt_q == 2'(N - 1));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 2'd0;
                end
            end
            BUSY: begin
                if (last_grp) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? BUSY : IDLE;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State and group counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // In-place transform of the current column group of the working register.
    always_comb begin
        logic [6:0] base;
        work_d = work_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            base = 7'(127 - 32 * (int'(cnt_q) * COLS_PER_CYCLE + g));
            work_d[base -: 32] = mix_col(work_q[base -: 32], inv_q);
        end
    end

    // Working register and mode: load on accept, update while BUSY.
    always_ff @(posedge clock) begin
        if (reset) begin
            work_q <= '0;
            inv_q  <= 1'b0;
        end else if (accept) begin
            work_q <= in_data;
            inv_q  <= in_inverse;
        end else if (state_q == BUSY) begin
            work_q <= work_d;
        end
    end

endmodule
